regbank_wb_arbiter: RTL

- Shares the register bank's single write port (we, addr_d, data_d) between two writeback requesters.
- ALU writeback is a non-buffered, high-priority source. Memory-load writeback is buffered in a small FIFO and drained in idle ALU slots.
- Exports a pending-write scoreboard so hazard logic can stall readers of registers that still have queued loads.
- Sits between the execute/memory stages and the register bank, and drives the bank's write inputs directly.

---
 rtl/regbank_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 93 +++++++++
 rtl/regbank_wb_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared types for the register-bank writeback arbiter: entry layout,
// source-select enum and an address decode helper.
package regbank_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 16;

    // One queued writeback: destination register and the value to write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Which requester owns the bank write port in the current cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

    // One-hot decode of a register address into a NUM_REGS-wide mask.
    function automatic logic [NUM_REGS-1:0] decode_addr(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending load writebacks. Pointers wrap modulo DEPTH and
// a separate count tracks occupancy, so DEPTH need not be a power of two.
// Also derives the mask of registers that still have a queued write.
module wb_fifo
    import regbank_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push_i,
    input  wb_entry_t           push_entry_i,
    input  logic                pop_i,
    output wb_entry_t           head_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [NUM_REGS-1:0] pending_mask_o
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state of storage, pointers and count for push and/or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // State registers; reset empties the buffer and drops any queued entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // OR of decoded destinations over the occupied slots only.
    always_comb begin
        int offset;
        pending_mask_o = '0;
        offset         = 0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = (i + DEPTH - int'(rd_ptr_q)) % DEPTH;
            if (offset < int'(count_q)) begin
                pending_mask_o = pending_mask_o | decode_addr(mem_q[i].addr);
            end
        end
    end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Arbitrates the register bank's single write port between a high-priority
// unbuffered ALU writeback and a FIFO-buffered load writeback, and exports a
// pending-write mask for hazard detection.
// Optional macro WB_AGE_LIMIT_EN: force the FIFO head out after it has waited
// MAX_WAIT cycles without being drained.
module regbank_wb_arbiter
    import regbank_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    input  logic [REG_ADDR_W-1:0]       alu_addr,
    input  logic [DATA_W-1:0]           alu_data,
    output logic                        alu_stall,
    input  logic                        mem_valid,
    input  logic [REG_ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]           mem_data,
    output logic                        mem_ready,
    output logic                        we,
    output logic [REG_ADDR_W-1:0]       addr_d,
    output logic [DATA_W-1:0]           data_d,
    input  logic [REG_ADDR_W-1:0]       qry_a,
    input  logic [REG_ADDR_W-1:0]       qry_b,
    output logic                        hazard_a,
    output logic                        hazard_b,
    output logic [NUM_REGS-1:0]         pending_mask,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || DEPTH > 8 || MAX_WAIT < 1) begin : g_bad_param
        $error("regbank_wb_arbiter: DEPTH must be 2..8 and MAX_WAIT at least 1");
    end

    wb_src_e               sel;
    logic                  fifo_forced;
    logic                  age_hit;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    wb_entry_t             fifo_head;
    wb_entry_t             push_entry;
    logic [NUM_REGS-1:0]   pending_w;
    logic [CNT_W-1:0]      count_w;

    logic                  bank_we_q, bank_we_d;
    logic [REG_ADDR_W-1:0] bank_addr_q, bank_addr_d;
    logic [DATA_W-1:0]     bank_data_q, bank_data_d;

    // Writes to r0 complete the handshake but never occupy a slot.
    assign mem_ready  = (count_w != CNT_W'(DEPTH));
    assign fifo_push  = mem_valid && mem_ready && (mem_addr != '0);
    assign push_entry = '{addr: mem_addr, data: mem_data};
    assign fifo_pop   = (sel == SRC_FIFO);

    wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (fifo_push),
        .push_entry_i   (push_entry),
        .pop_i          (fifo_pop),
        .head_o         (fifo_head),
        .count_o        (count_w),
        .full_o         (fifo_full),
        .empty_o        (fifo_empty),
        .pending_mask_o (pending_w)
    );

`ifdef WB_AGE_LIMIT_EN
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    logic [AGE_W-1:0] age_q, age_d;

    assign age_hit = !fifo_empty && (age_q == AGE_W'(MAX_WAIT));

    // Age of the current head: counts cycles it sits unpopped, clears on pop or empty.
    always_comb begin
        age_d = age_q;
        if (fifo_empty || fifo_pop) begin
            age_d = '0;
        end else if (age_q != AGE_W'(MAX_WAIT)) begin
            age_d = age_q + 1'b1;
        end
    end

    // Age counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign age_hit = 1'b0;
`endif

    // Source select: forced FIFO drains (age, full, WAW against a queued load)
    // beat the ALU; otherwise the ALU wins and the FIFO fills idle slots.
    always_comb begin
        sel         = SRC_NONE;
        fifo_forced = 1'b0;
        if (age_hit || fifo_full || (alu_valid && pending_w[alu_addr])) begin
            sel         = SRC_FIFO;
            fifo_forced = 1'b1;
        end else if (alu_valid && (alu_addr != '0)) begin
            sel = SRC_ALU;
        end else if (!fifo_empty) begin
            sel = SRC_FIFO;
        end
    end

    assign alu_stall = alu_valid && fifo_forced;

    // Next bank write: pulse we for the selected source, else hold address/data.
    always_comb begin
        bank_we_d   = 1'b0;
        bank_addr_d = bank_addr_q;
        bank_data_d = bank_data_q;
        case (sel)
            SRC_ALU: begin
                bank_we_d   = 1'b1;
                bank_addr_d = alu_addr;
                bank_data_d = alu_data;
            end
            SRC_FIFO: begin
                bank_we_d   = 1'b1;
                bank_addr_d = fifo_head.addr;
                bank_data_d = fifo_head.data;
            end
            default: begin
                bank_we_d = 1'b0;
            end
        endcase
    end

    // Registered write port toward the register bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_we_q   <= 1'b0;
            bank_addr_q <= '0;
            bank_data_q <= '0;
        end else begin
            bank_we_q   <= bank_we_d;
            bank_addr_q <= bank_addr_d;
            bank_data_q <= bank_data_d;
        end
    end

    assign we           = bank_we_q;
    assign addr_d       = bank_addr_q;
    assign data_d       = bank_data_q;
    assign pending_mask = pending_w;
    assign fifo_count   = count_w;
    assign hazard_a     = (qry_a != '0) && pending_w[qry_a];
    assign hazard_b     = (qry_b != '0) && pending_w[qry_b];

endmodule
